lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side counterpart of the team LFSR random generator: a self-synchronising PRBS checker.
- Accepts the generator's parallel output word on each valid beat and predicts the next word from the shared tap table.
- Acquires lock, then counts mismatching beats and declares loss of sync.
- Sits at the sink end of any link or datapath test driven by the generator, e.g. loopback BIST and NoC payload checking.

Parameters:
Length, 8, LFSR width; legal 3..168 (elaboration-time assertion outside range)
LockCnt, 4, consecutive correct predictions required to declare lock; >=1
LossCnt, 4, consecutive mismatches while locked that force re-acquisition; >=1
CntWidth, 16, width of the error counter

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
valid  input  1  data holds a new generator word this cycle
data  input  Length  received LFSR word
clr_cnt  input  1  clear error counter
locked  output  1  checker is in LOCKED state
err  output  1  one-cycle pulse: previous valid beat mismatched while locked
sync_loss  output  1  one-cycle pulse: lock dropped
err_cnt  output  CntWidth  saturating count of mismatching beats while locked

Behaviour:
- Reset: clk and rstn only; reset is synchronous and active-low. On rstn=0 at a clk edge: state=SEARCH, ref=0, match/miss counters=0, locked=0, err=0, sync_loss=0, err_cnt=0. Reset mid-operation discards lock and counts immediately.
- Next-word function (shared with generator): next(w) = {w[Length-2:0], fb}; fb = XOR of w[t-1] over nonzero taps t of the xapp052 table for Length.
- Only cycles with valid=1 advance the state; valid=0 holds everything. err and sync_loss are low on any non-valid cycle.
- SEARCH:
  - valid with data!=0: ref<=data, match<=0, go CHECK.
  - data==0 is the LFSR lock-up state and is never used as a seed; stay in SEARCH.
- CHECK:
  - valid and data==next(ref): ref<=data, match++. When match reaches LockCnt, go LOCKED; locked=1 on the following cycle.
  - valid and mismatch: reseed ref<=data (SEARCH rule, including the zero exception), match<=0, stay CHECK.
- LOCKED:
  - valid and data==next(ref): ref<=data, miss<=0.
  - valid and mismatch: ref<=next(ref) (flywheel; the received word is not trusted), miss++, err=1 next cycle, err_cnt++.
  - When miss reaches LossCnt: go SEARCH, locked=0 and sync_loss=1 on the next cycle, miss<=0.
- Latency: err, locked and sync_loss are registered, 1 cycle after the causing valid beat.
- err_cnt:
  - Saturates at all-ones; never wraps.
  - clr_cnt alone: err_cnt<=0.
  - clr_cnt with a counted error in the same cycle: err_cnt<=1.
  - Not cleared by lock loss.
- No errors are counted in SEARCH or CHECK.

Optional Feature:
- Macro: LFSR_CHECKER_BITCNT_EN.
- Defined:
  - Adds output bit_err_cnt [CntWidth].
  - Per mismatching beat in LOCKED, adds popcount(data ^ next(ref)), saturating.
  - Same clr_cnt rules; simultaneous case: bit_err_cnt<=popcount.
  - Reset 0.
- Undefined: port absent; no popcount logic.

Decomposition:
- Package lfsr_pkg holds:
  - function lfsr_taps(Length) returning the tap array;
  - function lfsr_next(w) (parameterised via Length argument), shared with the generator so both ends match by construction;
  - typedef enum lfsr_chk_state_t {SEARCH, CHECK, LOCKED}.
- One sub-module: lfsr_sat_cnt (width param, inc, inc_val, clr, sat count), used for err_cnt and, when enabled, bit_err_cnt.

Test Plan:
1. Lock: Length=8, LockCnt=4, generator seeded 8'h01, valid every cycle -> beats 1..4 CHECK; locked=1 one cycle after beat 5; err_cnt=0 for 1000 further beats.
2. Single error: locked, flip bit 0 of one beat -> err pulse exactly once, err_cnt=1, locked stays 1, next beats match with no further err.
3. Loss: locked, LossCnt=4, drive 4 consecutive corrupted beats -> err_cnt=4, sync_loss pulse after 4th, locked=0; clean stream resumes -> relock after 5 beats.
4. Zero/gaps: drive data=0 for 10 beats in SEARCH -> stays SEARCH, locked=0. Then a valid stream with valid toggling 1,0,1,0 -> lock after 5 valid beats; no err.
5. Counter edges: CntWidth=4, force 20 isolated errors -> err_cnt=15. clr_cnt coincident with an error -> err_cnt=1. rstn=0 mid-LOCKED -> all outputs 0 next cycle.
6. LFSR_CHECKER_BITCNT_EN: locked, one beat with 3 flipped bits -> bit_err_cnt=3, err_cnt=1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: xapp052 tap table, next-word function and checker states.
// Generator and checker both call lfsr_next so the two ends agree by construction.
package lfsr_pkg;

  localparam int MaxLen  = 168;
  localparam int MaxTaps = 6;

  typedef logic [MaxTaps-1:0][7:0] tap_arr_t;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lfsr_chk_state_t;

  function automatic tap_arr_t tp(input int a, input int b, input int c = 0, input int d = 0);
    return {8'(a), 8'(b), 8'(c), 8'(d), 16'd0};
  endfunction

  // Unused entries are zero; a zero entry is not a tap.
  function automatic tap_arr_t lfsr_taps(input int len);
    tap_arr_t t;
    t = '0;
    case (len)
      3: t = tp(3, 2);    4: t = tp(4, 3);    5: t = tp(5, 3);    6: t = tp(6, 5);
      7: t = tp(7, 6);    8: t = tp(8, 6, 5, 4);    9: t = tp(9, 5);    10: t = tp(10, 7);
      11: t = tp(11, 9);  12: t = tp(12, 6, 4, 1);  13: t = tp(13, 4, 3, 1);  14: t = tp(14, 5, 3, 1);
      15: t = tp(15, 14); 16: t = tp(16, 15, 13, 4); 17: t = tp(17, 14); 18: t = tp(18, 11);
      19: t = tp(19, 6, 2, 1); 20: t = tp(20, 17); 21: t = tp(21, 19); 22: t = tp(22, 21);
      23: t = tp(23, 18); 24: t = tp(24, 23, 22, 17); 25: t = tp(25, 22); 26: t = tp(26, 6, 2, 1);
      27: t = tp(27, 5, 2, 1); 28: t = tp(28, 25); 29: t = tp(29, 27); 30: t = tp(30, 6, 4, 1);
      31: t = tp(31, 28); 32: t = tp(32, 22, 2, 1); 33: t = tp(33, 20); 34: t = tp(34, 27, 2, 1);
      35: t = tp(35, 33); 36: t = tp(36, 25); 37: t = {8'd37, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      38: t = tp(38, 6, 5, 1); 39: t = tp(39, 35); 40: t = tp(40, 38, 21, 19); 41: t = tp(41, 38);
      42: t = tp(42, 41, 20, 19); 43: t = tp(43, 42, 38, 37); 44: t = tp(44, 43, 18, 17);
      45: t = tp(45, 44, 42, 41); 46: t = tp(46, 45, 26, 25); 47: t = tp(47, 42);
      48: t = tp(48, 47, 21, 20); 49: t = tp(49, 40); 50: t = tp(50, 49, 24, 23);
      51: t = tp(51, 50, 36, 35); 52: t = tp(52, 49); 53: t = tp(53, 52, 38, 37);
      54: t = tp(54, 53, 18, 17); 55: t = tp(55, 31); 56: t = tp(56, 55, 35, 34); 57: t = tp(57, 50);
      58: t = tp(58, 39); 59: t = tp(59, 58, 38, 37); 60: t = tp(60, 59); 61: t = tp(61, 60, 46, 45);
      62: t = tp(62, 61, 6, 5); 63: t = tp(63, 62); 64: t = tp(64, 63, 61, 60); 65: t = tp(65, 47);
      66: t = tp(66, 65, 57, 56); 67: t = tp(67, 66, 58, 57); 68: t = tp(68, 59);
      69: t = tp(69, 67, 42, 40); 70: t = tp(70, 69, 55, 54); 71: t = tp(71, 65);
      72: t = tp(72, 66, 25, 19); 73: t = tp(73, 48); 74: t = tp(74, 73, 59, 58);
      75: t = tp(75, 74, 65, 64); 76: t = tp(76, 75, 41, 40); 77: t = tp(77, 76, 47, 46);
      78: t = tp(78, 77, 59, 58); 79: t = tp(79, 70); 80: t = tp(80, 79, 43, 42); 81: t = tp(81, 77);
      82: t = tp(82, 79, 47, 44); 83: t = tp(83, 82, 38, 37); 84: t = tp(84, 71);
      85: t = tp(85, 84, 58, 57); 86: t = tp(86, 85, 74, 73); 87: t = tp(87, 74);
      88: t = tp(88, 87, 17, 16); 89: t = tp(89, 51); 90: t = tp(90, 89, 72, 71);
      91: t = tp(91, 90, 8, 7); 92: t = tp(92, 91, 80, 79); 93: t = tp(93, 91); 94: t = tp(94, 73);
      95: t = tp(95, 84); 96: t = tp(96, 94, 49, 47); 97: t = tp(97, 91); 98: t = tp(98, 87);
      99: t = tp(99, 97, 54, 52); 100: t = tp(100, 63); 101: t = tp(101, 100, 95, 94);
      102: t = tp(102, 101, 36, 35); 103: t = tp(103, 94); 104: t = tp(104, 103, 94, 93);
      105: t = tp(105, 89); 106: t = tp(106, 91); 107: t = tp(107, 105, 44, 42); 108: t = tp(108, 77);
      109: t = tp(109, 108, 103, 102); 110: t = tp(110, 109, 98, 97); 111: t = tp(111, 101);
      112: t = tp(112, 110, 69, 67); 113: t = tp(113, 104); 114: t = tp(114, 113, 33, 32);
      115: t = tp(115, 114, 101, 100); 116: t = tp(116, 115, 46, 45); 117: t = tp(117, 115, 99, 97);
      118: t = tp(118, 85); 119: t = tp(119, 111); 120: t = tp(120, 113, 9, 2); 121: t = tp(121, 103);
      122: t = tp(122, 121, 63, 62); 123: t = tp(123, 121); 124: t = tp(124, 87);
      125: t = tp(125, 124, 18, 17); 126: t = tp(126, 125, 90, 89); 127: t = tp(127, 126);
      128: t = tp(128, 126, 101, 99); 129: t = tp(129, 124); 130: t = tp(130, 127);
      131: t = tp(131, 130, 84, 83); 132: t = tp(132, 103); 133: t = tp(133, 132, 82, 81);
      134: t = tp(134, 77); 135: t = tp(135, 124); 136: t = tp(136, 135, 11, 10); 137: t = tp(137, 116);
      138: t = tp(138, 137, 131, 130); 139: t = tp(139, 136, 134, 131); 140: t = tp(140, 111);
      141: t = tp(141, 140, 110, 109); 142: t = tp(142, 121); 143: t = tp(143, 142, 123, 122);
      144: t = tp(144, 143, 75, 74); 145: t = tp(145, 93); 146: t = tp(146, 145, 87, 86);
      147: t = tp(147, 146, 110, 109); 148: t = tp(148, 121); 149: t = tp(149, 148, 40, 39);
      150: t = tp(150, 97); 151: t = tp(151, 148); 152: t = tp(152, 151, 87, 86); 153: t = tp(153, 152);
      154: t = tp(154, 152, 27, 25); 155: t = tp(155, 154, 124, 123); 156: t = tp(156, 155, 41, 40);
      157: t = tp(157, 156, 131, 130); 158: t = tp(158, 157, 132, 131); 159: t = tp(159, 128);
      160: t = tp(160, 159, 142, 141); 161: t = tp(161, 143); 162: t = tp(162, 161, 75, 74);
      163: t = tp(163, 162, 104, 103); 164: t = tp(164, 163, 151, 150);
      165: t = tp(165, 164, 135, 134); 166: t = tp(166, 165, 128, 127); 167: t = tp(167, 161);
      168: t = tp(168, 166, 153, 151);
      default: t = '0;
    endcase
    return t;
  endfunction

  // next(w) = {w[len-2:0], fb}; bits above len are forced to zero.
  function automatic logic [MaxLen-1:0] lfsr_next(input logic [MaxLen-1:0] w, input int len);
    tap_arr_t          t;
    logic              fb;
    logic [MaxLen-1:0] mask;
    t  = lfsr_taps(len);
    fb = 1'b0;
    for (int i = 0; i < MaxTaps; i++) begin
      if (t[i] != 8'd0) fb = fb ^ w[t[i] - 8'd1];
    end
    mask = (MaxLen'(1) << len) - MaxLen'(1);
    return ((w << 1) | MaxLen'(fb)) & mask;
  endfunction

endpackage

// File: rtl/lfsr_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear in the same cycle as an
// increment loads the increment value instead of zero.
module lfsr_sat_cnt #(
  parameter int Width    = 16,
  parameter int IncWidth = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                inc,
  input  logic [IncWidth-1:0] inc_val,
  output logic [Width-1:0]    cnt
);

  localparam int SumW = ((Width > IncWidth) ? Width : IncWidth) + 1;
  localparam logic [SumW-1:0] MaxVal = SumW'({Width{1'b1}});

  logic [SumW-1:0]  base;
  logic [SumW-1:0]  sum;
  logic [Width-1:0] sat;

  assign base = clr ? '0 : SumW'(cnt);
  assign sum  = base + SumW'(inc_val);
  assign sat  = (sum > MaxVal) ? '1 : sum[Width-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || inc) begin
      cnt <= inc ? sat : '0;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: seeds from the received stream, locks after
// LockCnt correct predictions, flywheels through errors. Define
// LFSR_CHECKER_BITCNT_EN to add the bit_err_cnt output.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int Length   = 8,
  parameter int LockCnt  = 4,
  parameter int LossCnt  = 4,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                valid,
  input  logic [Length-1:0]   data,
  input  logic                clr_cnt,
  output logic                locked,
  output logic                err,
  output logic                sync_loss,
  output logic [CntWidth-1:0] err_cnt,
`ifdef LFSR_CHECKER_BITCNT_EN
  output logic [CntWidth-1:0] bit_err_cnt,
`endif
  output lfsr_chk_state_t     dbg_state
);

  if (Length < 3 || Length > MaxLen || LockCnt < 1 || LossCnt < 1) begin : g_param_err
    $error("lfsr_checker: illegal parameter set");
  end

  localparam int MW = $clog2(LockCnt + 1);
  localparam int LW = $clog2(LossCnt + 1);

  // Handshake: a beat is transferred on every cycle with valid=1; there is no
  // backpressure. valid=0 cycles leave all state untouched.
  lfsr_chk_state_t   state_q, state_d;
  logic [Length-1:0] ref_q, ref_d, nxt;
  logic [MW-1:0]     match_q, match_d;
  logic [LW-1:0]     miss_q, miss_d;
  logic              err_q, err_d, loss_q, loss_d, hit;

  assign nxt = Length'(lfsr_next(MaxLen'(ref_q), Length));
  assign hit = (data == nxt);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    loss_d  = 1'b0;
    if (valid) begin
      case (state_q)
        SEARCH: begin
          if (data != '0) begin
            ref_d   = data;
            match_d = '0;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            ref_d = data;
            if (match_q == MW'(LockCnt - 1)) begin
              match_d = '0;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
            // The all-zero word cannot seed a prediction, so fall back to SEARCH.
            if (data != '0) ref_d = data;
            else state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (hit) begin
            ref_d  = data;
            miss_d = '0;
          end else begin
            ref_d = nxt;
            err_d = 1'b1;
            if (miss_q == LW'(LossCnt - 1)) begin
              miss_d  = '0;
              loss_d  = 1'b1;
              state_d = SEARCH;
            end else begin
              miss_d = miss_q + LW'(1);
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= SEARCH;
      ref_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      loss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      loss_q  <= loss_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign sync_loss = loss_q;
  assign dbg_state = state_q;

  lfsr_sat_cnt #(.Width(CntWidth), .IncWidth(1)) u_err_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr_cnt),
    .inc     (err_d),
    .inc_val (1'b1),
    .cnt     (err_cnt)
  );

`ifdef LFSR_CHECKER_BITCNT_EN
  localparam int PopW = $clog2(Length + 1);

  logic [Length-1:0] diff;
  logic [PopW-1:0]   pop;

  assign diff = data ^ nxt;

  always_comb begin
    pop = '0;
    for (int i = 0; i < Length; i++) pop = pop + PopW'(diff[i]);
  end

  lfsr_sat_cnt #(.Width(CntWidth), .IncWidth(PopW)) u_bit_err_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr_cnt),
    .inc     (err_d),
    .inc_val (pop),
    .cnt     (bit_err_cnt)
  );
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (Length=8, LockCnt=4, LossCnt=4, CntWidth=4).
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam int L  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid = 1'b0;
  logic [L-1:0]  data = '0;
  logic          clr_cnt = 1'b0;
  logic          locked, err, sync_loss;
  logic [CW-1:0] err_cnt;
`ifdef LFSR_CHECKER_BITCNT_EN
  logic [CW-1:0] bit_err_cnt;
`endif
  lfsr_chk_state_t dbg_state;

  int            n_vec = 0;
  int            n_err = 0;
  logic [L-1:0]  gen;
  logic [L-1:0]  exp_q[$];
  logic          err_seen;

  lfsr_checker #(.Length(L), .LockCnt(4), .LossCnt(4), .CntWidth(CW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid       (valid),
    .data        (data),
    .clr_cnt     (clr_cnt),
    .locked      (locked),
    .err         (err),
    .sync_loss   (sync_loss),
    .err_cnt     (err_cnt),
`ifdef LFSR_CHECKER_BITCNT_EN
    .bit_err_cnt (bit_err_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Independent model of the 8-bit generator: taps 8,6,5,4.
  function automatic logic [L-1:0] gen_next(input logic [L-1:0] w);
    return {w[6:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [L-1:0] d, input logic c);
    valid   = v;
    data    = d;
    clr_cnt = c;
    @(posedge clk);
    #1;
    valid   = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic send_good();
    gen = gen_next(gen);
    drive(1'b1, gen, 1'b0);
  endtask

  task automatic send_bad(input logic [L-1:0] flip, input logic c);
    gen = gen_next(gen);
    drive(1'b1, gen ^ flip, c);
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_sync_loss", 32'(sync_loss), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_state", 32'(dbg_state), 32'(SEARCH));
`ifdef LFSR_CHECKER_BITCNT_EN
    check("rst_bit_err_cnt", 32'(bit_err_cnt), 0);
`endif

    // 1: lock on the hand-computed sequence 01,02,04,08,11
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    for (int i = 0; i < 5; i++) begin
      gen = exp_q.pop_front();
      drive(1'b1, gen, 1'b0);
      check($sformatf("t1_locked_beat%0d", i + 1), 32'(locked), (i == 4) ? 1 : 0);
      if (i == 0) check("t1_state_check", 32'(dbg_state), 32'(CHECK));
    end
    err_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      send_good();
      err_seen = err_seen | err;
    end
    check("t1_no_err", 32'(err_seen), 0);
    check("t1_err_cnt", 32'(err_cnt), 0);
    check("t1_still_locked", 32'(locked), 1);

    // 2: single flipped bit
    send_bad(8'h01, 1'b0);
    check("t2_err", 32'(err), 1);
    check("t2_err_cnt", 32'(err_cnt), 1);
    check("t2_locked", 32'(locked), 1);
    drive(1'b0, 8'hff, 1'b0);
    check("t2_err_pulse", 32'(err), 0);
    check("t2_hold_cnt", 32'(err_cnt), 1);
    err_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_good();
      err_seen = err_seen | err;
    end
    check("t2_no_more_err", 32'(err_seen), 0);
    check("t2_err_cnt_after", 32'(err_cnt), 1);

    // 3: loss of sync
    drive(1'b0, 8'h00, 1'b1);
    check("t3_clr", 32'(err_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      send_bad(8'h80, 1'b0);
      check($sformatf("t3_sync_loss_%0d", i + 1), 32'(sync_loss), (i == 3) ? 1 : 0);
      check($sformatf("t3_locked_%0d", i + 1), 32'(locked), (i == 3) ? 0 : 1);
    end
    check("t3_err_cnt", 32'(err_cnt), 4);
    check("t3_state", 32'(dbg_state), 32'(SEARCH));
    drive(1'b0, 8'h00, 1'b0);
    check("t3_loss_pulse", 32'(sync_loss), 0);
    for (int i = 0; i < 5; i++) begin
      send_good();
      check($sformatf("t3_relock_%0d", i + 1), 32'(locked), (i == 4) ? 1 : 0);
    end
    check("t3_cnt_kept", 32'(err_cnt), 4);

    // 4: zero words in SEARCH, then a gapped stream
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h00, 1'b0);
    check("t4_zero_state", 32'(dbg_state), 32'(SEARCH));
    check("t4_zero_locked", 32'(locked), 0);
    err_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_good();
      err_seen = err_seen | err;
      drive(1'b0, 8'h00, 1'b0);
      err_seen = err_seen | err;
      if (i >= 3) check($sformatf("t4_gap_locked_%0d", i + 1), 32'(locked), (i == 4) ? 1 : 0);
    end
    check("t4_no_err", 32'(err_seen), 0);
    drive(1'b0, gen ^ 8'h5a, 1'b0);
    check("t4_invalid_ignored", 32'(err), 0);

    // 5: saturation, clear-with-error, reset mid-lock
    for (int i = 0; i < 20; i++) begin
      send_bad(8'h02, 1'b0);
      if (i == 0) check("t5_first", 32'(err_cnt), 1);
      if (i == 14) check("t5_at_15", 32'(err_cnt), 15);
      send_good();
    end
    check("t5_saturated", 32'(err_cnt), 15);
    check("t5_locked", 32'(locked), 1);
    send_bad(8'h10, 1'b1);
    check("t5_clr_with_err", 32'(err_cnt), 1);
    drive(1'b0, 8'h00, 1'b1);
    check("t5_clr_alone", 32'(err_cnt), 0);
    send_bad(8'h04, 1'b0);
    check("t5_pre_rst_err", 32'(err), 1);
    rstn = 1'b0;
    gen  = gen_next(gen);
    drive(1'b1, gen, 1'b0);
    check("t5_rst_locked", 32'(locked), 0);
    check("t5_rst_err", 32'(err), 0);
    check("t5_rst_sync_loss", 32'(sync_loss), 0);
    check("t5_rst_err_cnt", 32'(err_cnt), 0);
    rstn = 1'b1;

`ifdef LFSR_CHECKER_BITCNT_EN
    // 6: bit error count
    for (int i = 0; i < 5; i++) send_good();
    check("t6_locked", 32'(locked), 1);
    send_bad(8'h29, 1'b0);
    check("t6_bit_err_cnt", 32'(bit_err_cnt), 3);
    check("t6_err_cnt", 32'(err_cnt), 1);
    send_good();
    send_bad(8'h81, 1'b1);
    check("t6_bit_clr_with_err", 32'(bit_err_cnt), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
